dma_burst_engine: RTL and testbench

//  Multi-beat DMA load/store engine, successor to the single-command DMA load/store block.

---
 rtl/dma_burst_engine.sv | 184 ++++++++++++++++++
 tb/tb_dma_burst_engine.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_engine.sv
// Multi-beat DMA load/store engine: command port, word memory bus, rd/wr data streams.
// Build option DMA_STRIDE_EN: honour cmd_stride as the increment (else fixed at 1).
module dma_burst_engine #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 8,
    parameter int MODE_WIDTH   = 4,
    parameter int STRIDE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [SIZE_WIDTH-1:0]   cmd_size,
    input  logic [MODE_WIDTH-1:0]   cmd_mode,
    input  logic [STRIDE_WIDTH-1:0] cmd_stride,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_ready,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [MODE_WIDTH-1:0] MODE_LOAD  = MODE_WIDTH'(1);
    localparam logic [MODE_WIDTH-1:0] MODE_STORE = MODE_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        LD_OUT,
        ST_IN,
        ST_REQ,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [SIZE_WIDTH-1:0]   remain_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   incr;
    logic                    cmd_fire;
    logic                    is_load;
    logic                    is_store;
    logic                    size_zero;
    logic                    last_beat;
    logic                    beat_done;

    assign cmd_fire  = cmd_valid && (state_q == IDLE);
    assign is_load   = (cmd_mode == MODE_LOAD);
    assign is_store  = (cmd_mode == MODE_STORE);
    assign size_zero = (cmd_size == '0);
    assign last_beat = (remain_q == SIZE_WIDTH'(1));

`ifdef DMA_STRIDE_EN
    logic [STRIDE_WIDTH-1:0] stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else if (cmd_fire) begin
            stride_q <= cmd_stride;
        end
    end

    assign incr = ADDR_WIDTH'(stride_q);
`else
    logic unused_stride;

    assign unused_stride = ^cmd_stride;
    assign incr          = ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal modes and empty commands both retire through DONE; err_q picks the pulse.
    always_comb begin
        state_d   = state_q;
        beat_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    unique case (1'b1)
                        is_load:  state_d = size_zero ? DONE : LD_REQ;
                        is_store: state_d = size_zero ? DONE : ST_IN;
                        default:  state_d = DONE;
                    endcase
                end
            end
            LD_REQ: begin
                if (mem_gnt) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (mem_rvalid) begin
                    state_d = LD_OUT;
                end
            end
            LD_OUT: begin
                if (rd_ready) begin
                    beat_done = 1'b1;
                    state_d   = last_beat ? DONE : LD_REQ;
                end
            end
            ST_IN: begin
                if (wr_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    beat_done = 1'b1;
                    state_d   = last_beat ? DONE : ST_IN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            err_q    <= 1'b0;
        end else if (cmd_fire) begin
            addr_q   <= cmd_addr;
            remain_q <= cmd_size;
            err_q    <= !(is_load || is_store);
        end else if (beat_done) begin
            addr_q   <= addr_q + incr;
            remain_q <= remain_q - SIZE_WIDTH'(1);
        end
    end

    // One beat buffer serves both directions: read data out, or store data in.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if ((state_q == LD_WAIT) && mem_rvalid) begin
            data_q <= mem_rdata;
        end else if ((state_q == ST_IN) && wr_valid) begin
            data_q <= wr_data;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == LD_REQ) || (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ);
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign rd_valid  = (state_q == LD_OUT);
    assign rd_data   = data_q;
    assign wr_ready  = (state_q == ST_IN);
    assign done      = (state_q == DONE) && !err_q;
    assign err       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dma_burst_engine.sv
// Self-checking bench for dma_burst_engine: bus/stream environment plus queue-based model.
// Expected addresses follow DMA_STRIDE_EN the same way the build does.
module tb_dma_burst_engine;

    typedef logic [11:0] aq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_size = '0;
    logic [3:0]  cmd_mode = '0;
    logic [3:0]  cmd_stride = '0;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    dma_burst_engine dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .cmd_mode(cmd_mode), .cmd_stride(cmd_stride),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .err(err)
    );

    logic [31:0] mem [0:4095];
    int          checks = 0;
    int          errors = 0;
    bit          rand_mode = 0;
    int          gnt_delay = 0;
    int          rd_stall = 0;
    int          rd_lat = -1;
    int          gnt_wait = -1;
    int          stall_left = -1;
    logic [11:0] rd_addr_pend = '0;
    logic [11:0] raddr_log[$];
    logic [11:0] waddr_log[$];
    logic [31:0] wdata_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] src_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          req_cnt = 0;
    bit          hold_req = 0;
    bit          hold_rd = 0;
    logic [11:0] hold_addr = '0;
    logic        hold_we = 1'b0;
    logic [31:0] hold_data = '0;

    function automatic int model_inc(input logic [3:0] st);
`ifdef DMA_STRIDE_EN
        return int'(st);
`else
        return (st == 4'd0) ? 1 : 1;
`endif
    endfunction

    function automatic aq_t model_addrs(input logic [11:0] a, input int n, input logic [3:0] st);
        aq_t q;
        for (int i = 0; i < n; i++) begin
            q.push_back(12'((int'(a) + i * model_inc(st)) % 4096));
        end
        return q;
    endfunction

    // Environment: memory slave, load sink and store source, all decided on negedge.
    always @(negedge clk) begin
        if (rst) begin
            mem_gnt = 0; mem_rvalid = 0; rd_ready = 0; wr_valid = 0;
            rd_lat = -1; gnt_wait = -1; stall_left = -1;
            hold_req = 0; hold_rd = 0;
        end else begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (mem_req) req_cnt++;
            if (hold_req) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== hold_addr || mem_we !== hold_we) begin
                    errors++;
                    $display("FAIL req_hold: got req=%b addr=%h we=%b, need req=1 addr=%h we=%b",
                             mem_req, mem_addr, mem_we, hold_addr, hold_we);
                end
            end
            if (hold_rd) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== hold_data) begin
                    errors++;
                    $display("FAIL rd_hold: got valid=%b data=%h, need valid=1 data=%h",
                             rd_valid, rd_data, hold_data);
                end
            end
            if (rd_lat == 0) begin
                mem_rvalid = 1; mem_rdata = mem[rd_addr_pend]; rd_lat = -1;
            end else if (rd_lat > 0) begin
                mem_rvalid = 0; rd_lat--;
            end else begin
                mem_rvalid = rand_mode && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            hold_req = 0;
            if (mem_req) begin
                if (gnt_wait < 0) gnt_wait = rand_mode ? int'($urandom_range(0, 3)) : gnt_delay;
                if (gnt_wait == 0) begin
                    mem_gnt = 1; gnt_wait = -1;
                    if (mem_we) begin
                        waddr_log.push_back(mem_addr);
                        wdata_log.push_back(mem_wdata);
                        mem[mem_addr] = mem_wdata;
                    end else begin
                        raddr_log.push_back(mem_addr);
                        rd_addr_pend = mem_addr;
                        rd_lat = rand_mode ? int'($urandom_range(0, 2)) : 0;
                    end
                end else begin
                    mem_gnt = 0; gnt_wait--;
                    hold_req = 1; hold_addr = mem_addr; hold_we = mem_we;
                end
            end else begin
                mem_gnt = rand_mode && ($urandom_range(0, 1) == 1);
                gnt_wait = -1;
            end
            hold_rd = 0;
            if (rd_valid) begin
                if (stall_left < 0) stall_left = rand_mode ? int'($urandom_range(0, 2)) : rd_stall;
                if (stall_left == 0) begin
                    rd_ready = 1; rd_log.push_back(rd_data); stall_left = -1;
                end else begin
                    rd_ready = 0; stall_left--;
                    hold_rd = 1; hold_data = rd_data;
                end
            end else begin
                rd_ready = rand_mode && ($urandom_range(0, 1) == 1);
                stall_left = -1;
            end
            if (src_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
                wr_valid = 1; wr_data = src_q[0];
                if (wr_ready) void'(src_q.pop_front());
            end else begin
                wr_valid = 0; wr_data = $urandom;
            end
        end
    end

    task automatic clear_logs();
        raddr_log.delete(); waddr_log.delete(); wdata_log.delete(); rd_log.delete();
        done_cnt = 0; err_cnt = 0; req_cnt = 0;
    endtask

    task automatic issue(input logic [11:0] a, input logic [7:0] s, input logic [3:0] m,
                         input logic [3:0] st, output int cycles, output bit dropped);
        int w = 0;
        clear_logs();
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        cmd_valid = 1; cmd_addr = a; cmd_size = s; cmd_mode = m; cmd_stride = st;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = 12'($urandom); cmd_size = 8'($urandom);
        cmd_mode = 4'($urandom); cmd_stride = 4'($urandom);
        dropped = !cmd_ready;
        cycles = 1;
        while (!(done || err) && cycles < 4000) begin @(negedge clk); cycles++; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, mem_req, mem_we, rd_valid, wr_ready, busy, done, err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, need 10000000",
                     {cmd_ready, mem_req, mem_we, rd_valid, wr_ready, busy, done, err});
        end
        checks++;
        if ({mem_addr, mem_wdata, rd_data} !== 76'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, need zeros", mem_addr, mem_wdata, rd_data);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b, need 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_load_basic();
        int cyc; bit dr;
        rand_mode = 0; gnt_delay = 0; rd_stall = 0;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 32'(160 + i);
        issue(12'h100, 8'd8, 4'b0001, 4'd1, cyc, dr);
        checks++;
        if (!dr) begin errors++; $display("FAIL load_ready_drop: got cmd_ready=1 after accept, need 0"); end
        checks++;
        if (rd_log.size() != 8 || raddr_log.size() != 8) begin
            errors++;
            $display("FAIL load_beats: got %0d reads %0d outs, need 8", raddr_log.size(), rd_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (raddr_log[i] !== 12'(256 + i) || rd_log[i] !== 32'(160 + i)) begin
                    errors++;
                    $display("FAIL load_beat%0d: got addr=%h data=%h, need %h/%h",
                             i, raddr_log[i], rd_log[i], 12'(256 + i), 32'(160 + i));
                end
            end
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL load_done: got done=%0d err=%0d, need 1/0", done_cnt, err_cnt);
        end
        checks++;
        if (cyc != 25) begin errors++; $display("FAIL load_rate: got %0d cycles, need 25", cyc); end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL load_idle: got busy=%b ready=%b, need 0/1", busy, cmd_ready);
        end
    endtask

    task automatic test_store_basic();
        int cyc; bit dr;
        logic [31:0] ev[4];
        ev[0] = 32'h11; ev[1] = 32'h22; ev[2] = 32'h33; ev[3] = 32'h44;
        for (int i = 0; i < 4; i++) src_q.push_back(ev[i]);
        issue(12'h200, 8'd4, 4'b0010, 4'd1, cyc, dr);
        checks++;
        if (waddr_log.size() != 4) begin
            errors++; $display("FAIL store_beats: got %0d writes, need 4", waddr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (waddr_log[i] !== 12'(512 + i) || wdata_log[i] !== ev[i] || mem[512 + i] !== ev[i]) begin
                    errors++;
                    $display("FAIL store_beat%0d: got addr=%h data=%h, need %h/%h",
                             i, waddr_log[i], wdata_log[i], 12'(512 + i), ev[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || cyc != 9 || src_q.size() != 0) begin
            errors++;
            $display("FAIL store_done: got done=%0d cycles=%0d left=%0d, need 1/9/0", done_cnt, cyc, src_q.size());
        end
    endtask

    task automatic test_wrap();
        int cyc; bit dr;
        logic [11:0] ea[4];
        ea[0] = 12'hFFE; ea[1] = 12'hFFF; ea[2] = 12'h000; ea[3] = 12'h001;
        issue(12'hFFE, 8'd4, 4'b0001, 4'd1, cyc, dr);
        checks++;
        if (raddr_log.size() != 4 || rd_log.size() != 4) begin
            errors++; $display("FAIL wrap_beats: got %0d/%0d, need 4", raddr_log.size(), rd_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (raddr_log[i] !== ea[i] || rd_log[i] !== mem[ea[i]]) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: got addr=%h data=%h, need %h/%h",
                             i, raddr_log[i], rd_log[i], ea[i], mem[ea[i]]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int cyc; bit dr;
        issue(12'h123, 8'd5, 4'b0100, 4'd1, cyc, dr);
        checks++;
        if (err_cnt != 1 || done_cnt != 0 || req_cnt != 0 || cyc != 1 || !dr) begin
            errors++;
            $display("FAIL illegal_mode: got err=%0d done=%0d req=%0d cyc=%0d drop=%0d, need 1/0/0/1/1",
                     err_cnt, done_cnt, req_cnt, cyc, dr);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b, need 1", cmd_ready); end
        issue(12'h080, 8'd0, 4'b0001, 4'd1, cyc, dr);
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || req_cnt != 0 || cyc != 1 || !dr) begin
            errors++;
            $display("FAIL size_zero: got done=%0d err=%0d req=%0d cyc=%0d drop=%0d, need 1/0/0/1/1",
                     done_cnt, err_cnt, req_cnt, cyc, dr);
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit dr;
        aq_t ea;
        gnt_delay = 3; rd_stall = 5;
        ea = model_addrs(12'h040, 4, 4'd1);
        issue(12'h040, 8'd4, 4'b0001, 4'd1, cyc, dr);
        checks++;
        if (rd_log.size() != 4 || raddr_log.size() != 4) begin
            errors++; $display("FAIL bp_beats: got %0d/%0d, need 4", raddr_log.size(), rd_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (raddr_log[i] !== ea[i] || rd_log[i] !== mem[ea[i]]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got addr=%h data=%h, need %h/%h",
                             i, raddr_log[i], rd_log[i], ea[i], mem[ea[i]]);
                end
            end
        end
        checks++;
        if (cyc != 45 || done_cnt != 1) begin
            errors++; $display("FAIL bp_timing: got cyc=%0d done=%0d, need 45/1", cyc, done_cnt);
        end
        gnt_delay = 0; rd_stall = 0;
    endtask

    task automatic test_stride();
        int cyc; bit dr;
        aq_t ea;
        ea = model_addrs(12'h010, 3, 4'd4);
        issue(12'h010, 8'd3, 4'b0001, 4'd4, cyc, dr);
        checks++;
        if (raddr_log.size() != 3) begin
            errors++; $display("FAIL stride_beats: got %0d, need 3", raddr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (raddr_log[i] !== ea[i]) begin
                    errors++; $display("FAIL stride_addr%0d: got %h, need %h", i, raddr_log[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit dr; int w = 0;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 32'(160 + i);
        clear_logs();
        cmd_valid = 1; cmd_addr = 12'h100; cmd_size = 8'd8; cmd_mode = 4'b0001; cmd_stride = 4'd1;
        @(negedge clk);
        cmd_valid = 0;
        while (rd_log.size() < 3 && w < 200) begin @(negedge clk); w++; end
        @(posedge clk); #2 rst = 1;
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 12'h0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b ready=%b req=%b addr=%h rdata=%h, need 0/1/0/0/0",
                     busy, cmd_ready, mem_req, mem_addr, rd_data);
        end
        req_cnt = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != 0 || req_cnt != 0 || rd_log.size() != 3) begin
            errors++;
            $display("FAIL abort_quiet: got done=%0d req=%0d beats=%0d, need 0/0/3", done_cnt, req_cnt, rd_log.size());
        end else begin
            checks++;
            if (rd_log[2] !== 32'hA2) begin errors++; $display("FAIL abort_partial: got %h, need a2", rd_log[2]); end
        end
        for (int i = 0; i < 3; i++) src_q.push_back(32'h5A00 + 32'(i));
        issue(12'h300, 8'd3, 4'b0010, 4'd1, cyc, dr);
        checks++;
        if (done_cnt != 1 || waddr_log.size() != 3) begin
            errors++; $display("FAIL post_abort_store: got done=%0d writes=%0d, need 1/3", done_cnt, waddr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (waddr_log[i] !== 12'(768 + i) || wdata_log[i] !== 32'h5A00 + 32'(i)) begin
                    errors++;
                    $display("FAIL post_abort_beat%0d: got %h/%h, need %h/%h",
                             i, waddr_log[i], wdata_log[i], 12'(768 + i), 32'h5A00 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        int cyc; bit dr; int n; int r;
        logic [11:0] a; logic [3:0] st; logic [3:0] m;
        logic [31:0] ed[$];
        aq_t ea;
        rand_mode = 1;
        for (int k = 0; k < 30; k++) begin
            a = 12'($urandom); st = 4'($urandom); n = $urandom_range(0, 10);
            r = $urandom_range(0, 9);
            m = (r < 4) ? 4'b0001 : (r < 8) ? 4'b0010 : 4'($urandom_range(3, 15));
            ea = model_addrs(a, n, st);
            ed.delete();
            if (m == 4'b0010) begin
                for (int i = 0; i < n; i++) begin ed.push_back($urandom); src_q.push_back(ed[i]); end
            end
            issue(a, 8'(n), m, st, cyc, dr);
            if (m != 4'b0001 && m != 4'b0010) begin
                checks++;
                if (err_cnt != 1 || done_cnt != 0 || req_cnt != 0) begin
                    errors++;
                    $display("FAIL rnd%0d_illegal: got err=%0d done=%0d req=%0d, need 1/0/0", k, err_cnt, done_cnt, req_cnt);
                end
            end else begin
                checks++;
                if (done_cnt != 1 || err_cnt != 0 || !dr) begin
                    errors++; $display("FAIL rnd%0d_done: got done=%0d err=%0d, need 1/0", k, done_cnt, err_cnt);
                end
                if (m == 4'b0001) begin
                    checks++;
                    if (raddr_log.size() != n || rd_log.size() != n) begin
                        errors++;
                        $display("FAIL rnd%0d_ld_beats: got %0d/%0d, need %0d", k, raddr_log.size(), rd_log.size(), n);
                    end else begin
                        for (int i = 0; i < n; i++) begin
                            checks++;
                            if (raddr_log[i] !== ea[i] || rd_log[i] !== mem[ea[i]]) begin
                                errors++;
                                $display("FAIL rnd%0d_ld%0d: got %h/%h, need %h/%h",
                                         k, i, raddr_log[i], rd_log[i], ea[i], mem[ea[i]]);
                            end
                        end
                    end
                end else begin
                    checks++;
                    if (waddr_log.size() != n) begin
                        errors++; $display("FAIL rnd%0d_st_beats: got %0d, need %0d", k, waddr_log.size(), n);
                    end else begin
                        for (int i = 0; i < n; i++) begin
                            checks++;
                            if (waddr_log[i] !== ea[i] || wdata_log[i] !== ed[i]) begin
                                errors++;
                                $display("FAIL rnd%0d_st%0d: got %h/%h, need %h/%h",
                                         k, i, waddr_log[i], wdata_log[i], ea[i], ed[i]);
                            end
                        end
                    end
                end
            end
            src_q.delete();
        end
        rand_mode = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        test_reset();
        test_load_basic();
        test_store_basic();
        test_wrap();
        test_illegal();
        test_backpressure();
        test_stride();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
